// File: rtl/single_pulse_pacer_pkg.sv
// -----------------------------------------------------------------------------
// single_pulse_pacer_pkg
// Shared async-domain definitions for the pulse pacer: the FSM state encoding
// and the width of the guard down-counter.
// -----------------------------------------------------------------------------
package single_pulse_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2
  } pacer_state_e;

  // Guard counter width; covers P_GUARD_CYC up to 255.
  localparam int unsigned GUARD_W = 8;

endpackage

// File: rtl/single_pulse_pacer_cnt.sv
// -----------------------------------------------------------------------------
// sat_updown_cnt
// Saturating up/down counter holding the number of queued events.
// A coincident inc and dec leave the count unchanged; the count never wraps.
// Ports:
//   i_clk_a  clock
//   i_rst_a  asynchronous active-high reset
//   i_inc    increment request
//   i_dec    decrement request
//   i_clr    synchronous clear (priority over inc/dec)
//   o_cnt    current count
//   o_full   count is at all-ones
//   o_empty  count is zero
// -----------------------------------------------------------------------------
module sat_updown_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk_a,
  input  logic         i_rst_a,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign o_full  = (cnt_q == {W{1'b1}});
  assign o_empty = (cnt_q == '0);
  assign o_cnt   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && !i_dec && !o_full) begin
      cnt_d = cnt_q + W'(1);
    end else if (i_dec && !i_inc && !o_empty) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_clk_a or posedge i_rst_a) begin
    if (i_rst_a) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/single_pulse_pacer.sv
// -----------------------------------------------------------------------------
// single_pulse_pacer
// Turns a stream of single-cycle event requests into one-cycle pulses spaced
// at least P_GUARD_CYC cycles apart, queueing events that arrive too early.
// Optional build macro: SINGLE_PULSE_PACER_DROP_CNT_EN enables the dropped
// event counter on o_drop_cnt (otherwise it reads 0).
// Ports:
//   i_clk_a     clock
//   i_rst_a     asynchronous active-high reset
//   i_event     event request (may assert every cycle)
//   i_enable    allow issuing; events are still queued when low
//   i_clr       synchronous clear of queued events (and drop count)
//   o_single_a  registered one-cycle output pulse
//   o_pending   queued, not yet issued events
//   o_overflow  one-cycle pulse when an event is dropped at full
//   o_busy      high while issuing or guarding
//   o_drop_cnt  saturating count of dropped events
// -----------------------------------------------------------------------------
module single_pulse_pacer
  import single_pulse_pacer_pkg::*;
#(
  parameter int unsigned P_GUARD_CYC = 16,
  parameter int unsigned P_PEND_W    = 4
) (
  input  logic                i_clk_a,
  input  logic                i_rst_a,
  input  logic                i_event,
  input  logic                i_enable,
  input  logic                i_clr,
  output logic                o_single_a,
  output logic [P_PEND_W-1:0] o_pending,
  output logic                o_overflow,
  output logic                o_busy,
  output logic [15:0]         o_drop_cnt
);

  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(P_GUARD_CYC - 2);

  pacer_state_e       state_q, state_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic               single_q, single_d;
  logic               overflow_q, overflow_d;

  logic pend_full, pend_empty, pend_inc, pend_dec;
  logic ev_eff, issue_ok, issue_now, direct_issue;

  // A cleared cycle discards its event entirely.
  assign ev_eff = i_event && !i_clr;

  // The last guard cycle behaves as IDLE so back-to-back pulses are spaced
  // exactly P_GUARD_CYC cycles.
  assign issue_ok     = (state_q == ST_IDLE) ||
                        ((state_q == ST_GUARD) && (guard_q == '0));
  assign issue_now    = issue_ok && i_enable && (!pend_empty || ev_eff);
  assign direct_issue = issue_now && pend_empty;
  assign pend_dec     = issue_now && !pend_empty;
  // At full, an event is still accepted if a queued one leaves this cycle.
  assign pend_inc     = ev_eff && !direct_issue && (!pend_full || pend_dec);
  assign overflow_d   = ev_eff && !direct_issue && pend_full && !pend_dec;

  sat_updown_cnt #(
    .W (P_PEND_W)
  ) u_pend_cnt (
    .i_clk_a (i_clk_a),
    .i_rst_a (i_rst_a),
    .i_inc   (pend_inc),
    .i_dec   (pend_dec),
    .i_clr   (i_clr),
    .o_cnt   (o_pending),
    .o_full  (pend_full),
    .o_empty (pend_empty)
  );

  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    single_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue_now) begin
          state_d  = ST_ISSUE;
          single_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_GUARD;
        guard_d = GUARD_LOAD;
      end
      ST_GUARD: begin
        if (guard_q == '0) begin
          if (issue_now) begin
            state_d  = ST_ISSUE;
            single_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          guard_d = guard_q - GUARD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        guard_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk_a or posedge i_rst_a) begin
    if (i_rst_a) begin
      state_q    <= ST_IDLE;
      guard_q    <= '0;
      single_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      single_q   <= single_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_single_a = single_q;
  assign o_overflow = overflow_q;
  assign o_busy     = (state_q != ST_IDLE);

`ifdef SINGLE_PULSE_PACER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Counts in step with the overflow flop so both update on the same edge.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (i_clr) begin
      drop_cnt_d = '0;
    end else if (overflow_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk_a or posedge i_rst_a) begin
    if (i_rst_a) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_single_pulse_pacer.sv
// -----------------------------------------------------------------------------
// tb_single_pulse_pacer
// Self-checking bench: directed scenarios plus randomized traffic, compared
// cycle by cycle against a time-based behavioural model of the pacer.
// -----------------------------------------------------------------------------
module tb_single_pulse_pacer;

  localparam int GC   = 16;
  localparam int PW   = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic          i_clk_a;
  logic          i_rst_a;
  logic          i_event;
  logic          i_enable;
  logic          i_clr;
  logic          o_single_a;
  logic [PW-1:0] o_pending;
  logic          o_overflow;
  logic          o_busy;
  logic [15:0]   o_drop_cnt;

  single_pulse_pacer #(
    .P_GUARD_CYC (GC),
    .P_PEND_W    (PW)
  ) dut (
    .i_clk_a    (i_clk_a),
    .i_rst_a    (i_rst_a),
    .i_event    (i_event),
    .i_enable   (i_enable),
    .i_clr      (i_clr),
    .o_single_a (o_single_a),
    .o_pending  (o_pending),
    .o_overflow (o_overflow),
    .o_busy     (o_busy),
    .o_drop_cnt (o_drop_cnt)
  );

  initial i_clk_a = 1'b0;
  always #5 i_clk_a = ~i_clk_a;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: time of last pulse, queue depth, drop count.
  int cyc     = 0;
  bit m_have  = 0;
  int m_last  = 0;
  int m_pend  = 0;
  int m_drop  = 0;
  bit m_single = 0;
  bit m_ovf    = 0;
  int peak     = 0;
  int pulse_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int exp_drop();
`ifdef SINGLE_PULSE_PACER_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic step(input bit ev, input bit en, input bit clr);
    bit ev_eff, allowed, issue, busy;
    @(negedge i_clk_a);
    i_event  = ev;
    i_enable = en;
    i_clr    = clr;
    ev_eff  = ev && !clr;
    allowed = !m_have || ((cyc - m_last) >= GC - 1);
    issue   = allowed && en && ((m_pend > 0) || ev_eff);
    m_ovf   = 0;
    if (issue && m_pend > 0)       m_pend = m_pend - 1 + (ev_eff ? 1 : 0);
    else if (!issue && ev_eff) begin
      if (m_pend == PMAX) m_ovf = 1;
      else                m_pend++;
    end
    if (clr) m_pend = 0;
    if (clr)                         m_drop = 0;
    else if (m_ovf && m_drop < 65535) m_drop++;
    if (issue) begin
      m_have = 1;
      m_last = cyc + 1;
    end
    m_single = issue;
    cyc++;
    busy = m_have && ((cyc - m_last) <= GC - 1);
    @(posedge i_clk_a);
    #1;
    chk("single",   32'(o_single_a), 32'(m_single));
    chk("pending",  32'(o_pending),  32'(m_pend));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("busy",     32'(o_busy),     32'(busy));
    chk("drop_cnt", 32'(o_drop_cnt), 32'(exp_drop()));
    if (o_single_a) pulse_q.push_back(cyc);
    if (int'(o_pending) > peak) peak = int'(o_pending);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_single"},  32'(o_single_a), 0);
    chk({tag, "_pending"}, 32'(o_pending),  0);
    chk({tag, "_ovf"},     32'(o_overflow), 0);
    chk({tag, "_busy"},    32'(o_busy),     0);
    chk({tag, "_drop"},    32'(o_drop_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge i_clk_a);
    i_event  = 0;
    i_enable = 0;
    i_clr    = 0;
    i_rst_a  = 1;
    #1;
    check_zero("rst_async");
    m_have = 0; m_pend = 0; m_drop = 0;
    repeat (2) @(posedge i_clk_a);
    #1;
    check_zero("rst_hold");
    @(negedge i_clk_a);
    i_rst_a = 0;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(0, en, 0);
  endtask

  initial begin
    i_rst_a  = 1;
    i_event  = 0;
    i_enable = 0;
    i_clr    = 0;
    #2;
    check_zero("por");
    do_reset();

    // Single event from idle: pulse next cycle, nothing queued.
    idle(9, 1);
    step(1, 1, 0);
    chk("direct_pulse", 32'(o_single_a), 1);
    chk("direct_pend",  32'(o_pending),  0);
    idle(20, 1);

    // Burst of five back-to-back events.
    pulse_q.delete();
    peak = 0;
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    idle(80, 1);
    chk("burst_npulse", 32'(pulse_q.size()), 5);
    chk("burst_peak",   32'(peak), 4);
    for (int i = 1; i < pulse_q.size(); i++)
      chk("burst_space", 32'(pulse_q[i] - pulse_q[i-1]), GC);

    // Fill while disabled, with two drops, then drain.
    for (int i = 0; i < PMAX + 2; i++) step(1, 0, 0);
    chk("fill_pend", 32'(o_pending), PMAX);
`ifdef SINGLE_PULSE_PACER_DROP_CNT_EN
    chk("fill_drop", 32'(o_drop_cnt), 2);
`else
    chk("fill_drop", 32'(o_drop_cnt), 0);
`endif
    pulse_q.delete();
    idle(PMAX * GC + 4, 1);
    chk("drain_npulse", 32'(pulse_q.size()), PMAX);
    chk("drain_pend",   32'(o_pending), 0);

    // Event coincident with an issue from a full queue: accepted, no drop.
    for (int i = 0; i < PMAX; i++) step(1, 0, 0);
    step(1, 1, 0);
    chk("full_issue_pend", 32'(o_pending), PMAX);
    chk("full_issue_ovf",  32'(o_overflow), 0);
    step(0, 1, 1);
    idle(GC + 2, 1);

    // Clear with a coincident event while two are queued, mid-guard.
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    chk("clr_pend", 32'(o_pending), 0);
    chk("clr_busy", 32'(o_busy), 1);
    idle(GC + 2, 1);

    // Reset mid-guard with three queued, then a clean direct pulse.
    step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    idle(3, 1);
    do_reset();
    step(1, 1, 0);
    chk("post_rst_pulse", 32'(o_single_a), 1);
    idle(GC, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 40,
             $urandom_range(0, 99) < 85,
             $urandom_range(0, 99) < 3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/single_pulse_pacer.md
SINGLE_PULSE_PACER -- requirements
Module: single_pulse_pacer

Interface
REQ-001 Parameter P_GUARD_CYC, default 16: minimum clk_a cycles from one o_single_a pulse to the next; legal range 2..255.
REQ-002 Parameter P_PEND_W, default 4: width of the pending-event counter; capacity is 2^P_PEND_W-1.
REQ-003 i_clk_a  input  1  clock.
REQ-004 i_rst_a  input  1  reset; asynchronous, active-high.
REQ-005 i_event  input  1  single-cycle event request; may assert on consecutive cycles.
REQ-006 i_enable  input  1  issue enable; when low, events are still counted but not issued.
REQ-007 i_clr  input  1  synchronous clear of pending events.
REQ-008 o_single_a  output  1  registered one-cycle pulse; feeds the clk_a side of the pulse synchronizer.
REQ-009 o_pending  output  P_PEND_W  number of queued, unissued events.
REQ-010 o_overflow  output  1  one-cycle pulse when an event is dropped at full.
REQ-011 o_busy  output  1  high in ISSUE or GUARD.
REQ-012 o_drop_cnt  output  16  saturating count of dropped events; see Configuration.

Function
REQ-013 The FSM SHALL have three states: IDLE, ISSUE and GUARD.
REQ-014 IDLE->ISSUE SHALL occur when i_enable=1 and either (o_pending>0) or (i_event=1).
REQ-015 ISSUE SHALL last exactly one cycle, with o_single_a=1 during that cycle only, and SHALL always go next to GUARD.
REQ-016 GUARD SHALL load its down-counter with P_GUARD_CYC-2 on entry and SHALL return to IDLE when the counter reaches 0, independent of i_enable.
REQ-017 This gives a minimum spacing of exactly P_GUARD_CYC cycles between rising edges of o_single_a.
REQ-018 Latency: i_event at cycle n, with the FSM in IDLE, i_enable=1 and o_pending=0, SHALL give o_single_a=1 at cycle n+1 and SHALL NOT increment o_pending.
REQ-019 In every other case, an accepted i_event SHALL increment o_pending.
REQ-020 Entering ISSUE from pending events SHALL decrement o_pending in that same transition.
REQ-021 If an increment and a decrement coincide in one cycle, o_pending SHALL be unchanged.
REQ-022 Full: i_event while o_pending=2^P_PEND_W-1 and no decrement in that cycle SHALL be dropped and SHALL pulse o_overflow for one cycle.
REQ-023 If a decrement occurs in that same cycle, the event SHALL be accepted instead (net zero, no overflow).
REQ-024 i_clr SHALL zero o_pending on the next edge and SHALL have priority over a coincident i_event, which is discarded without overflow.
REQ-025 i_clr SHALL NOT abort ISSUE or GUARD.
REQ-026 i_enable low SHALL hold o_pending and block only the IDLE->ISSUE transition.
REQ-027 o_pending SHALL never wrap in either direction.

Reset
REQ-028 While i_rst_a is asserted: FSM=IDLE, guard counter=0, o_single_a=0, o_pending=0, o_overflow=0, o_busy=0, o_drop_cnt=0.
REQ-029 Assertion of i_rst_a mid-GUARD or mid-ISSUE SHALL discard all in-flight and pending events.
REQ-030 The first i_event after reset deassertion SHALL be handled per REQ-018.

Configuration
REQ-031 Macro SINGLE_PULSE_PACER_DROP_CNT_EN.
REQ-032 With the macro defined: o_drop_cnt SHALL increment on each o_overflow pulse, saturate at 16'hFFFF, and clear on i_clr or reset.
REQ-033 Without the macro: o_drop_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized.
REQ-034 The port list SHALL be identical in both builds.

Structure
REQ-035 The FSM state encoding (IDLE/ISSUE/GUARD) and the guard-width constant (8 bits) SHALL live in the shared async package.
REQ-036 A single sub-module, sat_updown_cnt (parameterized width; inc/dec/clr; full/empty flags), SHALL implement the pending counter.
REQ-037 All other logic SHALL be flat in single_pulse_pacer.

Verification
REQ-038 Single event, idle, i_enable=1, P_GUARD_CYC=16: i_event at cycle 10 -> o_single_a high only at cycle 11; o_busy high cycles 11..26; o_pending stays 0.
REQ-039 Burst of 5 consecutive i_event from cycle 10 -> pulses at cycles 11, 27, 43, 59, 75; o_pending peaks at 4 and returns to 0.
REQ-040 P_PEND_W=2, i_enable=0, 5 events -> o_pending=3, o_overflow pulses twice, o_drop_cnt=2 (macro on) or 0 (macro off); raising i_enable then yields 3 pulses spaced 16 cycles.
REQ-041 i_event coincident with the ISSUE transition at full (o_pending=3, P_PEND_W=2) -> o_pending stays 3, no o_overflow.
REQ-042 i_clr together with i_event while o_pending=2 -> o_pending=0 next cycle, no o_overflow, and any in-progress GUARD completes normally.
REQ-043 i_rst_a asserted at GUARD cycle 5 with o_pending=3 -> all outputs 0; after release, one i_event -> pulse exactly 1 cycle later.
